// File: rtl/roberto_responder_pkg.sv
// Shared definitions for the roberto_responder sensor-frame receiver/replier:
// state codes, default parameter values and a counter-width helper.
package roberto_responder_pkg;

    localparam int DEF_N_SENSORES     = 3;
    localparam int DEF_BYTES_SENSOR   = 4;
    localparam int DEF_N_RESPOSTA     = 2;
    localparam int DEF_TIMEOUT_CICLOS = 50000;

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        ESPERA_BYTE = 4'd1,
        ARMAZENA    = 4'd2,
        PROX_SENSOR = 4'd3,
        FRAME_OK    = 4'd4,
        ENVIA       = 4'd5,
        ESPERA_TX   = 4'd6,
        PROX_RESP   = 4'd7,
        FINAL       = 4'd8,
        TIMEOUT     = 4'd9
    } estado_t;

    // Bits needed to hold every value 0..max_val (at least one bit).
    function automatic int largura(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/roberto_timeout.sv
// Inter-byte watchdog: counts while enabled and flags fim on reaching
// TIMEOUT_CICLOS-1, where it holds until cleared.
module roberto_timeout
    import roberto_responder_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = DEF_TIMEOUT_CICLOS
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int              W_CNT  = largura(TIMEOUT_CICLOS - 1);
    localparam logic [W_CNT-1:0] LIMITE = W_CNT'(TIMEOUT_CICLOS - 1);

    logic [W_CNT-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (zera) begin
            r_cnt <= '0;
        end else if (conta && !fim) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign fim = (r_cnt == LIMITE);

endmodule

// File: rtl/roberto_responder.sv
// Receives a frame of N_SENSORES*BYTES_SENSOR bytes, publishes it on medidas,
// then sends N_RESPOSTA reply bytes through a start/done transmitter handshake.
module roberto_responder
    import roberto_responder_pkg::*;
#(
    parameter int N_SENSORES     = DEF_N_SENSORES,
    parameter int BYTES_SENSOR   = DEF_BYTES_SENSOR,
    parameter int N_RESPOSTA     = DEF_N_RESPOSTA,
    parameter int TIMEOUT_CICLOS = DEF_TIMEOUT_CICLOS
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   habilita,
    input  logic [7:0]                             rx_dado,
    input  logic                                   rx_pronto,
    input  logic                                   tx_pronto,
    input  logic [8*N_RESPOSTA-1:0]                resposta,
    output logic                                   partida_tx,
    output logic [7:0]                             tx_dado,
    output logic [8*N_SENSORES*BYTES_SENSOR-1:0]   medidas,
    output logic                                   medidas_validas,
    output logic                                   erro_timeout,
    output logic                                   pronto,
    output logic [3:0]                             db_estado
);

    localparam int N_BYTES = N_SENSORES * BYTES_SENSOR;
    localparam int W_BYTE  = largura(BYTES_SENSOR);
    localparam int W_SENS  = largura(N_SENSORES);
    localparam int W_IDX   = largura(N_RESPOSTA);
    localparam int W_SLOT  = largura(N_BYTES - 1);

    localparam logic [W_BYTE-1:0] ULT_BYTE   = W_BYTE'(BYTES_SENSOR - 1);
    localparam logic [W_SENS-1:0] ULT_SENS   = W_SENS'(N_SENSORES - 1);
    localparam logic [W_IDX-1:0]  ULT_IDX    = W_IDX'(N_RESPOSTA - 1);
    localparam logic [W_SLOT-1:0] SLOT_PASSO = W_SLOT'(BYTES_SENSOR);

    estado_t                 r_estado;
    estado_t                 w_prox;
    logic [W_BYTE-1:0]       r_byte;
    logic [W_SENS-1:0]       r_sensor;
    logic [W_IDX-1:0]        r_idx;
    logic [8*N_BYTES-1:0]    r_buffer;
    logic [8*N_BYTES-1:0]    r_medidas;
    logic [8*N_RESPOSTA-1:0] r_resposta;
    logic                    r_validas;

    logic [W_SLOT-1:0]       w_slot;
    logic                    w_rx_aceito;
    logic                    w_iniciado;
    logic                    w_zera;
    logic                    w_conta;
    logic                    w_fim;

    assign w_rx_aceito = (r_estado == ESPERA_BYTE) && rx_pronto;
    assign w_iniciado  = (r_byte != '0) || (r_sensor != '0);
    assign w_slot      = W_SLOT'(r_sensor) * SLOT_PASSO + W_SLOT'(r_byte);

    // The watchdog only runs once a frame is under way, so an idle line never aborts.
    assign w_zera  = (r_estado == OCIOSO) || w_rx_aceito;
    assign w_conta = (r_estado == ARMAZENA) || (r_estado == PROX_SENSOR) ||
                     ((r_estado == ESPERA_BYTE) && w_iniciado);

    roberto_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (w_zera),
        .conta (w_conta),
        .fim   (w_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_prox       = r_estado;
        partida_tx   = 1'b0;
        erro_timeout = 1'b0;
        pronto       = 1'b0;
        case (r_estado)
            OCIOSO:      if (habilita) w_prox = ESPERA_BYTE;
            ESPERA_BYTE: begin
                if (rx_pronto)                 w_prox = ARMAZENA;
                else if (w_fim && w_iniciado)  w_prox = TIMEOUT;
            end
            ARMAZENA:    w_prox = (r_byte == ULT_BYTE) ? PROX_SENSOR : ESPERA_BYTE;
            PROX_SENSOR: w_prox = (r_sensor == ULT_SENS) ? FRAME_OK : ESPERA_BYTE;
            FRAME_OK:    w_prox = ENVIA;
            ENVIA: begin
                partida_tx = 1'b1;
                w_prox     = ESPERA_TX;
            end
            ESPERA_TX:   if (tx_pronto) w_prox = PROX_RESP;
            PROX_RESP:   w_prox = (r_idx == ULT_IDX) ? FINAL : ENVIA;
            FINAL: begin
                pronto = 1'b1;
                w_prox = OCIOSO;
            end
            TIMEOUT: begin
                erro_timeout = 1'b1;
                w_prox       = OCIOSO;
            end
            default:     w_prox = OCIOSO;
        endcase
    end

    // NOTE: the frame buffer has no reset; every slot is rewritten before it is ever published.
    always_ff @(posedge clock) begin
        if (w_rx_aceito) begin
            for (int s = 0; s < N_BYTES; s++) begin
                if (w_slot == W_SLOT'(s)) r_buffer[8*s +: 8] <= rx_dado;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_byte     <= '0;
            r_sensor   <= '0;
            r_idx      <= '0;
            r_medidas  <= '0;
            r_resposta <= '0;
            r_validas  <= 1'b0;
        end else begin
            r_validas <= (r_estado == FRAME_OK);
            case (r_estado)
                OCIOSO: begin
                    r_byte   <= '0;
                    r_sensor <= '0;
                    r_idx    <= '0;
                end
                ARMAZENA:    r_byte <= r_byte + 1'b1;
                PROX_SENSOR: begin
                    r_byte   <= '0;
                    r_sensor <= r_sensor + 1'b1;
                end
                FRAME_OK: begin
                    r_medidas  <= r_buffer;
                    r_resposta <= resposta;
                end
                // The reply register shifts so the byte being sent always sits in [7:0].
                PROX_RESP: begin
                    r_idx      <= r_idx + 1'b1;
                    r_resposta <= r_resposta >> 8;
                end
                default: ;
            endcase
        end
    end

    assign tx_dado         = r_resposta[7:0];
    assign medidas         = r_medidas;
    assign medidas_validas = r_validas;
    assign db_estado       = r_estado;

endmodule

// File: tb/tb_roberto_responder.sv
// Self-checking bench for roberto_responder: table of full frames with a
// reply scoreboard, plus hand sequences for timeout and reset corner cases.
`timescale 1ns/1ps
module tb_roberto_responder;
    import roberto_responder_pkg::*;

    localparam int NS = DEF_N_SENSORES;
    localparam int BS = DEF_BYTES_SENSOR;
    localparam int NR = DEF_N_RESPOSTA;
    localparam int NB = NS * BS;
    localparam int TO = 100;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            habilita = 1'b0;
    logic [7:0]      rx_dado = 8'h00;
    logic            rx_pronto = 1'b0;
    logic            tx_pronto = 1'b0;
    logic [8*NR-1:0] resposta = '0;
    logic            partida_tx;
    logic [7:0]      tx_dado;
    logic [8*NB-1:0] medidas;
    logic            medidas_validas;
    logic            erro_timeout;
    logic            pronto;
    logic [3:0]      db_estado;

    roberto_responder #(
        .N_SENSORES     (NS),
        .BYTES_SENSOR   (BS),
        .N_RESPOSTA     (NR),
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .rx_dado         (rx_dado),
        .rx_pronto       (rx_pronto),
        .tx_pronto       (tx_pronto),
        .resposta        (resposta),
        .partida_tx      (partida_tx),
        .tx_dado         (tx_dado),
        .medidas         (medidas),
        .medidas_validas (medidas_validas),
        .erro_timeout    (erro_timeout),
        .pronto          (pronto),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] resposta;
        logic [7:0]  base;
        int          gap;
        bit          inject;
        logic [7:0]  exp_tx0;
        logic [7:0]  exp_tx1;
        logic [7:0]  exp_lo;
        logic [7:0]  exp_hi;
    } vec_t;

    vec_t            vecs[3];
    logic [7:0]      q_tx[$];
    logic [8*NB-1:0] q_med[$];
    logic [8*NB-1:0] last_med = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_partida = 0, n_valid = 0, n_erro = 0, n_pronto = 0;

    always @(negedge clock) begin
        if (partida_tx)      n_partida++;
        if (medidas_validas) n_valid++;
        if (erro_timeout)    n_erro++;
        if (pronto)          n_pronto++;
    end

    task automatic check(input string nome, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", nome, got, exp);
        end
    endtask

    task automatic fail_bound(input string nome);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not seen within its cycle budget", nome);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dado   = b;
        rx_pronto = 1'b1;
        tick();
        rx_pronto = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        logic [8*NB-1:0] exp_med;
        logic [7:0]      exp_tx;
        int k, p0, v0, d0, waited;
        p0 = n_partida; v0 = n_valid; d0 = n_pronto;
        resposta = v.resposta;
        q_tx.push_back(v.exp_tx0);
        q_tx.push_back(v.exp_tx1);
        for (int i = 0; i < NB; i++) exp_med[8*i +: 8] = v.base + 8'(i);
        q_med.push_back(exp_med);

        habilita = 1'b1;
        tick();
        habilita = 1'b0;
        for (int i = 0; i < NB; i++) begin
            send_byte(v.base + 8'(i));
            if (i != NB - 1) tick(v.gap - 1);
        end

        k = 0;
        while (!medidas_validas && k < 20) begin tick(); k++; end
        if (!medidas_validas) begin
            fail_bound("medidas_validas");
            return;
        end
        check("medidas", medidas, q_med.pop_front());
        check("medidas_lo", medidas[7:0], v.exp_lo);
        check("medidas_hi", medidas[8*NB-1 -: 8], v.exp_hi);
        last_med = exp_med;

        for (int r = 0; r < NR; r++) begin
            k = 0;
            while (!partida_tx && k < 50) begin tick(); k++; end
            if (!partida_tx) begin
                fail_bound("partida_tx");
                return;
            end
            exp_tx = q_tx.pop_front();
            check("tx_dado", tx_dado, exp_tx);
            tick();
            waited = 1;
            if (v.inject) begin
                send_byte(8'hEE);
                tick();
                send_byte(8'h77);
                waited += 3;
            end
            tick(10 - waited);
            check("tx_dado_hold", tx_dado, exp_tx);
            tx_pronto = 1'b1;
            tick();
            tx_pronto = 1'b0;
        end

        k = 0;
        while (!pronto && k < 20) begin tick(); k++; end
        if (!pronto) begin
            fail_bound("pronto");
            return;
        end
        tick(2);
        check("n_partida", n_partida - p0, NR);
        check("n_validas", n_valid - v0, 1);
        check("n_pronto", n_pronto - d0, 1);
        check("estado_fim", db_estado, OCIOSO);
    endtask

    initial begin
        int k, cyc, e0, v0, d0;

        vecs[0] = '{resposta: 16'hBEEF, base: 8'h01, gap: 20, inject: 1'b0,
                    exp_tx0: 8'hEF, exp_tx1: 8'hBE, exp_lo: 8'h01, exp_hi: 8'h0C};
        vecs[1] = '{resposta: 16'h1234, base: 8'hA0, gap: 3, inject: 1'b1,
                    exp_tx0: 8'h34, exp_tx1: 8'h12, exp_lo: 8'hA0, exp_hi: 8'hAB};
        vecs[2] = '{resposta: 16'h00FF, base: 8'hF8, gap: 7, inject: 1'b0,
                    exp_tx0: 8'hFF, exp_tx1: 8'h00, exp_lo: 8'hF8, exp_hi: 8'h03};

        // Reset state
        tick();
        check("rst0_estado", db_estado, OCIOSO);
        check("rst0_medidas", medidas, '0);
        check("rst0_tx_dado", tx_dado, 8'h00);
        check("rst0_pulsos", {partida_tx, medidas_validas, erro_timeout, pronto}, 4'b0000);
        tick(2);
        reset = 1'b1;
        tick(2);

        // habilita held low: bytes must be ignored, FSM stays idle
        send_byte(8'h55);
        tick(2);
        send_byte(8'hAA);
        tick(5);
        check("idle_estado", db_estado, OCIOSO);
        check("idle_validas", n_valid, 0);
        check("idle_medidas", medidas, '0);

        for (int i = 0; i < 3; i++) run_frame(vecs[i]);

        // Timeout after 5 bytes of a partial frame
        e0 = n_erro; v0 = n_valid;
        habilita = 1'b1;
        tick();
        habilita = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h50 + 8'(i));
            if (i < 4) tick(4);
        end
        cyc = 0;
        while (!erro_timeout && cyc < 300) begin tick(); cyc++; end
        if (!erro_timeout) fail_bound("erro_timeout");
        check("timeout_ciclos", cyc, TO);
        check("timeout_medidas", medidas, last_med);
        tick();
        check("timeout_estado", db_estado, OCIOSO);
        tick();
        check("timeout_pulsos", n_erro - e0, 1);
        check("timeout_validas", n_valid - v0, 0);

        // A full frame after the aborted one must land from slot 0
        run_frame(vecs[0]);

        // Reset while waiting on the transmitter
        resposta = 16'hCAFE;
        habilita = 1'b1;
        tick();
        habilita = 1'b0;
        for (int i = 0; i < NB; i++) begin
            send_byte(8'h30 + 8'(i));
            if (i != NB - 1) tick(2);
        end
        k = 0;
        while (!partida_tx && k < 50) begin tick(); k++; end
        if (!partida_tx) fail_bound("rst_partida");
        check("rst_pre_tx", tx_dado, 8'hFE);
        tick(3);
        check("rst_pre_estado", db_estado, ESPERA_TX);
        d0 = n_pronto;
        #2 reset = 1'b0;
        #1;
        check("rst_estado", db_estado, OCIOSO);
        check("rst_tx_dado", tx_dado, 8'h00);
        check("rst_medidas", medidas, '0);
        check("rst_pulsos", {partida_tx, medidas_validas, erro_timeout, pronto}, 4'b0000);
        tick(2);
        reset = 1'b1;
        tx_pronto = 1'b1;
        tick();
        tx_pronto = 1'b0;
        tick(10);
        check("rst_sem_pronto", n_pronto - d0, 0);
        check("rst_estado_pos", db_estado, OCIOSO);

        // Normal operation resumes after the abort
        run_frame(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/roberto_responder.md
ROBERTO_RESPONDER -- requirements
Module: roberto_responder

Interface
REQ-001 The block SHALL have parameter N_SENSORES, default 3, the number of sensors per received frame.
REQ-002 The block SHALL have parameter BYTES_SENSOR, default 4, the number of bytes per sensor.
REQ-003 The block SHALL have parameter N_RESPOSTA, default 2, the number of reply bytes sent per frame.
REQ-004 The block SHALL have parameter TIMEOUT_CICLOS, default 50000, the maximum clock cycles allowed between bytes inside a frame.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port habilita, input, 1, which starts frame reception when high in OCIOSO.
REQ-008 The block SHALL have port rx_dado, input, 8, the received byte, valid while rx_pronto=1.
REQ-009 The block SHALL have port rx_pronto, input, 1, a one-cycle pulse per received byte.
REQ-010 The block SHALL have port tx_pronto, input, 1, the transmitter pulse marking the end of a byte.
REQ-011 The block SHALL have port resposta, input, 8*N_RESPOSTA, the reply bytes, byte 0 in bits [7:0].
REQ-012 The block SHALL have port partida_tx, output, 1, a one-cycle transmitter start pulse.
REQ-013 The block SHALL have port tx_dado, output, 8, the byte to transmit, stable from partida_tx until tx_pronto.
REQ-014 The block SHALL have port medidas, output, 8*N_SENSORES*BYTES_SENSOR, the last complete frame, first-received byte in bits [7:0].
REQ-015 The block SHALL have port medidas_validas, output, 1, a one-cycle pulse when medidas updates.
REQ-016 The block SHALL have port erro_timeout, output, 1, a one-cycle pulse on a frame abort.
REQ-017 The block SHALL have port pronto, output, 1, a one-cycle pulse when all reply bytes are sent.
REQ-018 The block SHALL have port db_estado, output, 4, the current state code.

Function
REQ-019 The FSM SHALL use states and codes OCIOSO=0, ESPERA_BYTE=1, ARMAZENA=2, PROX_SENSOR=3, FRAME_OK=4, ENVIA=5, ESPERA_TX=6, PROX_RESP=7, FINAL=8, TIMEOUT=9; db_estado SHALL equal the code, and any other code SHALL go to OCIOSO.
REQ-020 In OCIOSO the block SHALL clear the byte, sensor, reply and timer counters, and SHALL go to ESPERA_BYTE when habilita=1.
REQ-021 In ESPERA_BYTE, rx_pronto=1 SHALL write rx_dado into buffer slot sensor*BYTES_SENSOR+byte on that edge, clear the timer, and go to ARMAZENA.
REQ-022 In ESPERA_BYTE the timer SHALL count only after the first byte of a frame; on reaching TIMEOUT_CICLOS-1 without rx_pronto the FSM SHALL go to TIMEOUT, and rx_pronto SHALL win if both occur in the same cycle.
REQ-023 In ARMAZENA the byte counter SHALL increment; the FSM SHALL go to PROX_SENSOR if the byte index was BYTES_SENSOR-1, else to ESPERA_BYTE.
REQ-024 In PROX_SENSOR the byte counter SHALL clear and the sensor counter SHALL increment; the FSM SHALL go to FRAME_OK if the sensor index was N_SENSORES-1, else to ESPERA_BYTE.
REQ-025 In FRAME_OK, medidas SHALL load from the buffer, resposta SHALL be registered, medidas_validas SHALL pulse, and the FSM SHALL go to ENVIA.
REQ-026 In ENVIA, partida_tx=1 and tx_dado=registered reply byte[idx] for one cycle, then the FSM SHALL go to ESPERA_TX.
REQ-027 In ESPERA_TX the block SHALL hold tx_dado and go to PROX_RESP on tx_pronto=1.
REQ-028 In PROX_RESP idx SHALL increment; the FSM SHALL go to FINAL if idx was N_RESPOSTA-1, else to ENVIA.
REQ-029 In FINAL, pronto SHALL pulse and the FSM SHALL go to OCIOSO; in TIMEOUT, erro_timeout SHALL pulse, the partial frame SHALL be discarded with medidas unchanged, and the FSM SHALL go to OCIOSO.
REQ-030 rx_pronto outside ESPERA_BYTE SHALL be ignored (byte dropped), tx_pronto outside ESPERA_TX SHALL be ignored, and habilita SHALL be ignored outside OCIOSO.
REQ-031 All counters SHALL be sized to their maximum value and SHALL never wrap within a frame.

Reset
REQ-032 When reset=0 the block SHALL asynchronously set state=OCIOSO, clear all counters, and set medidas=0, tx_dado=0, and partida_tx, medidas_validas, erro_timeout and pronto to 0; a reset mid-frame or mid-reply SHALL abort without any pulse.

Structure
REQ-033 State codes and the default parameter values SHALL live in a shared include file used by this block and its testbench.
REQ-034 The inter-byte timer SHALL be one sub-module, roberto_timeout, with inputs clock, reset, zera and conta, and output fim.

Verification
REQ-035 Bench: habilita pulse, then 12 bytes 0x01..0x0C spaced 20 cycles -> one medidas_validas pulse; medidas[7:0]=0x01 and [95:88]=0x0C.
REQ-036 Bench: after a frame with resposta=16'hBEEF and tx_pronto 10 cycles after each partida_tx -> tx_dado=0xEF, then 0xBE; exactly two partida_tx pulses, then pronto.
REQ-037 Bench: with TIMEOUT_CICLOS=100, 5 bytes then silence -> erro_timeout exactly 100 cycles after the 5th byte; medidas unchanged; db_estado returns to 0.
REQ-038 Bench: rx_pronto pulses during ESPERA_TX -> ignored; next frame's byte 0 lands in slot 0.
REQ-039 Bench: reset=0 while in ESPERA_TX -> outputs 0 immediately, db_estado=0, no pronto pulse.
REQ-040 Bench: habilita held low after reset -> FSM stays in OCIOSO and rx_pronto pulses cause no buffer writes.
